// File: rtl/pcie_rst_pkg.sv
// pcie_rst_pkg: shared state encoding and sizing helpers for the PERST# receive sequencer.
package pcie_rst_pkg;
  localparam int SEQ_STATE_W = 3;
  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_CORE_REL  = 3'd2,
    ST_WAIT_LINK = 3'd3,
    ST_USER_REL  = 3'd4,
    ST_LINK_UP   = 3'd5,
    ST_TIMEOUT   = 3'd6
  } seq_state_e;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/rst_sync_bit.sv
// rst_sync_bit: STAGES-deep synchroniser whose flops clear asynchronously to 0.
module rst_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pcie_perst_rx_sequencer.sv
// pcie_perst_rx_sequencer: debounces PERST#, sequences core then user resets, watches link-up.
module pcie_perst_rx_sequencer #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int CORE_HOLD_CYCLES = 500,
  parameter int USER_DELAY       = 8,
  parameter int LINK_TIMEOUT     = 4096
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       perst_n,
  input  logic       user_lnk_up,
  output logic       core_rst_n,
  output logic       user_rst_n,
  output logic       link_timeout,
  output logic       link_drop,
  output logic [2:0] seq_state
);
  import pcie_rst_pkg::*;
  localparam int CNT_MAX = max2(max2(DEBOUNCE_CYCLES, CORE_HOLD_CYCLES), max2(USER_DELAY, LINK_TIMEOUT));
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(CORE_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] USER_LAST = CW'(USER_DELAY - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LINK_TIMEOUT - 1);
  localparam bit TO_EN = (LINK_TIMEOUT != 0);
  logic rst_n_s, perst_s;
  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic drop_d;
  logic core_rst_n_q, user_rst_n_q, link_timeout_q, link_drop_q;
  // Reset asserts asynchronously but releases only after SYNC_STAGES clean edges.
  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(1'b1), .q_o(rst_n_s)
  );
  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_perst_sync (
    .clk_i(sys_clk), .rst_n_i(rst_n_s), .d_i(perst_n), .q_o(perst_s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (!perst_s) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
        ST_DEBOUNCE: begin
          cnt_d   = (cnt_q == DEB_LAST) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == DEB_LAST) ? ST_CORE_REL : ST_DEBOUNCE;
        end
        ST_CORE_REL: begin
          cnt_d   = (cnt_q == HOLD_LAST) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == HOLD_LAST) ? ST_WAIT_LINK : ST_CORE_REL;
        end
        ST_WAIT_LINK: begin
          if (user_lnk_up) begin
            state_d = ST_USER_REL;
            cnt_d   = '0;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
            cnt_d   = '0;
          end else if (TO_EN) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_USER_REL: begin
          if (!user_lnk_up) begin
            state_d = ST_WAIT_LINK;
            cnt_d   = '0;
          end else begin
            cnt_d   = (cnt_q == USER_LAST) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == USER_LAST) ? ST_LINK_UP : ST_USER_REL;
          end
        end
        ST_LINK_UP: begin
          if (!user_lnk_up) begin
            state_d = ST_WAIT_LINK;
            cnt_d   = '0;
            drop_d  = 1'b1;
          end
        end
        ST_TIMEOUT: begin
          if (user_lnk_up) begin
            state_d = ST_USER_REL;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end
  // Outputs decode from next state so they change on the same edge as the state.
  always_ff @(posedge sys_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      core_rst_n_q   <= 1'b0;
      user_rst_n_q   <= 1'b0;
      link_timeout_q <= 1'b0;
      link_drop_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      core_rst_n_q   <= (state_d == ST_WAIT_LINK) || (state_d == ST_USER_REL) ||
                        (state_d == ST_LINK_UP) || (state_d == ST_TIMEOUT);
      user_rst_n_q   <= (state_d == ST_LINK_UP);
      link_timeout_q <= link_timeout_q || (state_d == ST_TIMEOUT);
      link_drop_q    <= drop_d;
    end
  end
  assign core_rst_n   = core_rst_n_q;
  assign user_rst_n   = user_rst_n_q;
  assign link_timeout = link_timeout_q;
  assign link_drop    = link_drop_q;
  assign seq_state    = state_q;
endmodule

// File: tb/tb_pcie_perst_rx_sequencer.sv
// tb_pcie_perst_rx_sequencer: directed self-checking bench for the PERST# receive sequencer.
module tb_pcie_perst_rx_sequencer;
  logic clk = 1'b0;
  logic sys_rst_n, perst_n, user_lnk_up;
  logic core_rst_n, user_rst_n, link_timeout, link_drop;
  logic [2:0] seq_state;
  int checks = 0;
  int failures = 0;
  int n;
  logic seen;
  always #5 clk = ~clk;
  pcie_perst_rx_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CORE_HOLD_CYCLES(500),
    .USER_DELAY(8), .LINK_TIMEOUT(4096)
  ) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .perst_n(perst_n), .user_lnk_up(user_lnk_up),
    .core_rst_n(core_rst_n), .user_rst_n(user_rst_n), .link_timeout(link_timeout),
    .link_drop(link_drop), .seq_state(seq_state)
  );
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic pick(input int s);
    return (s == 0) ? core_rst_n : (s == 1) ? user_rst_n : link_timeout;
  endfunction
  // Counts edges until the selected output goes high; an expired bound returns lim.
  task automatic cycles_to(input int s, input int lim, output int cnt);
    cnt = 0;
    while (!pick(s) && cnt < lim) begin
      tick(1);
      cnt++;
    end
  endtask
  initial begin
    sys_rst_n = 1'b0;
    perst_n = 1'b0;
    user_lnk_up = 1'b0;
    tick(3);
    chk("rst_state", seq_state, 0);
    chk("rst_core", core_rst_n, 0);
    chk("rst_user", user_rst_n, 0);
    chk("rst_timeout", link_timeout, 0);
    chk("rst_drop", link_drop, 0);
    sys_rst_n = 1'b1;
    tick(5);
    chk("idle_hold", seq_state, 0);
    // 1: full bring-up
    perst_n = 1'b1;
    tick(10);
    chk("t1_debounce", seq_state, 1);
    cycles_to(0, 700, n);
    chk("t1_core_lat", n + 10, 519);
    chk("t1_wait_link", seq_state, 3);
    chk("t1_user_low", user_rst_n, 0);
    tick(100);
    user_lnk_up = 1'b1;
    cycles_to(1, 50, n);
    chk("t1_user_lat", n, 9);
    chk("t1_link_up", seq_state, 5);
    chk("t1_core_high", core_rst_n, 1);
    chk("t1_no_timeout", link_timeout, 0);
    // 4: single-cycle link drop
    user_lnk_up = 1'b0;
    tick(1);
    chk("t4_drop", link_drop, 1);
    chk("t4_user", user_rst_n, 0);
    chk("t4_state", seq_state, 3);
    chk("t4_core", core_rst_n, 1);
    user_lnk_up = 1'b1;
    tick(1);
    chk("t4_drop_end", link_drop, 0);
    chk("t4_user_rel", seq_state, 4);
    tick(7);
    chk("t4_user_early", user_rst_n, 0);
    tick(1);
    chk("t4_user_back", user_rst_n, 1);
    // 5: PERST# fall coinciding with link-up fall at the FSM
    perst_n = 1'b0;
    tick(2);
    chk("t5_core_still", core_rst_n, 1);
    user_lnk_up = 1'b0;
    tick(1);
    chk("t5_core", core_rst_n, 0);
    chk("t5_user", user_rst_n, 0);
    chk("t5_state", seq_state, 0);
    chk("t5_no_drop", link_drop, 0);
    // 2: short PERST# glitch
    tick(5);
    perst_n = 1'b1;
    tick(10);
    chk("t2_debounce", seq_state, 1);
    perst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen = seen | core_rst_n;
    end
    chk("t2_core_never", seen, 0);
    chk("t2_hold", seq_state, 0);
    // 3: link timeout
    perst_n = 1'b1;
    cycles_to(0, 700, n);
    chk("t3_core_lat", n, 519);
    cycles_to(2, 5000, n);
    chk("t3_timeout_lat", n, 4096);
    chk("t3_state", seq_state, 6);
    chk("t3_core", core_rst_n, 1);
    tick(20);
    user_lnk_up = 1'b1;
    cycles_to(1, 50, n);
    chk("t3_user_lat", n, 9);
    chk("t3_sticky", link_timeout, 1);
    chk("t3_link_up", seq_state, 5);
    // link_timeout survives PERST#
    perst_n = 1'b0;
    user_lnk_up = 1'b0;
    tick(3);
    chk("t3_perst_hold", seq_state, 0);
    chk("t3_sticky_perst", link_timeout, 1);
    // 6: async reset mid CORE_REL
    perst_n = 1'b1;
    tick(100);
    chk("t6_core_rel", seq_state, 2);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_async_state", seq_state, 0);
    chk("t6_async_timeout", link_timeout, 0);
    chk("t6_async_core", core_rst_n, 0);
    tick(2);
    sys_rst_n = 1'b1;
    cycles_to(0, 700, n);
    chk("t6_restart_lat", n, 521);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
